hex_scan_display: RTL and testbench

HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

---
 rtl/hex_scan_display.sv | 124 ++++++++++++
 tb/tb_hex_scan_display.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_display.sv
// hex_scan_display: 8-digit multiplexed seven-segment driver for a 32-bit hex word.
// Define LEADING_ZERO_BLANK_EN to darken digits above the most significant nonzero nibble.
module hex_scan_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic        value_we,
  input  logic        blank,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam logic [15:0] LAST = 16'(REFRESH_DIV - 1);

  logic [15:0] prescaler;
  logic [2:0]  digit_idx;
  logic [31:0] shadow;
  logic [31:0] display;
  logic        pending;
  logic        tick;
  logic [3:0]  nibble;
  logic        digit_lit;
  logic [7:0]  an_next;
  logic [6:0]  seg_next;

  assign tick       = (prescaler == LAST);
  assign frame_done = tick && (digit_idx == 3'd7);
  assign nibble     = display[{digit_idx, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      digit_idx <= '0;
    end else if (tick) begin
      prescaler <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end

  // The display register only changes on the frame boundary so a frame never tears;
  // a write landing exactly on that boundary bypasses the shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
    end else begin
      if (value_we) begin
        shadow <= value_in;
      end
      if (frame_done) begin
        pending <= 1'b0;
        if (value_we) begin
          display <= value_in;
        end else if (pending) begin
          display <= shadow;
        end
      end else if (value_we) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0] top_digit;

  always_comb begin
    top_digit = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (display[4*k +: 4] != 4'h0) begin
        top_digit = 3'(k);
      end
    end
  end

  assign digit_lit = (digit_idx <= top_digit);
`else
  assign digit_lit = 1'b1;
`endif

  always_comb begin
    seg_next = 7'h7F;
    case (nibble)
      4'h0: seg_next = 7'h40;
      4'h1: seg_next = 7'h79;
      4'h2: seg_next = 7'h24;
      4'h3: seg_next = 7'h30;
      4'h4: seg_next = 7'h19;
      4'h5: seg_next = 7'h12;
      4'h6: seg_next = 7'h02;
      4'h7: seg_next = 7'h78;
      4'h8: seg_next = 7'h00;
      4'h9: seg_next = 7'h10;
      4'hA: seg_next = 7'h08;
      4'hB: seg_next = 7'h03;
      4'hC: seg_next = 7'h46;
      4'hD: seg_next = 7'h21;
      4'hE: seg_next = 7'h06;
      4'hF: seg_next = 7'h0E;
      default: seg_next = 7'h7F;
    endcase
    an_next = ~(8'd1 << digit_idx);
    if (blank || !digit_lit) begin
      an_next  = 8'hFF;
      seg_next = 7'h7F;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// tb_hex_scan_display: directed scan/anti-tearing/blank checks with a cycle-tagged scoreboard.
// Expected digit patterns are hand-written per test; LEADING_ZERO_BLANK_EN selects lit masks.
module tb_hex_scan_display;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value_in;
  logic        value_we;
  logic        blank;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  hex_scan_display #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .value_we   (value_we),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [6:0] seg;
    logic       fd;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  localparam logic [55:0] ZERO_SEGS = {8{7'h40}};
  localparam logic [55:0] BB_SEGS   = {{6{7'h40}}, 7'h03, 7'h03};
  localparam logic [55:0] NUM_SEGS  = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
  localparam logic [55:0] F_SEGS    = {{4{7'h40}}, {4{7'h0E}}};

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LIT_ZERO = 8'h01;
  localparam logic [7:0] LIT_BB   = 8'h03;
  localparam logic [7:0] LIT_F    = 8'h0F;
`else
  localparam logic [7:0] LIT_ZERO = 8'hFF;
  localparam logic [7:0] LIT_BB   = 8'hFF;
  localparam logic [7:0] LIT_F    = 8'hFF;
`endif

  task automatic check_output(input string tag, input logic [7:0] a_exp,
                              input logic [6:0] s_exp, input logic f_exp);
    vectors++;
    if (an !== a_exp || seg !== s_exp || frame_done !== f_exp) begin
      miscompares++;
      $display("[TB] FAIL %s cyc=%0d an=%h want %h, seg=%h want %h, frame_done=%b want %b",
               tag, cyc, an, a_exp, seg, s_exp, frame_done, f_exp);
    end
  endtask

  task automatic push_item(input int c, input logic [7:0] a, input logic [6:0] s,
                           input logic f, input string tag);
    exp_t e;
    e.cyc = c;
    e.an  = a;
    e.seg = s;
    e.fd  = f;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Frame whose boundary (frame_done cycle) is f: digit k is visible on cycles f+4k+2..f+4k+5.
  task automatic push_frame(input int f, input logic [55:0] segs, input logic [7:0] lit,
                            input int last_cyc, input string tag);
    logic [7:0] a;
    logic [6:0] s;
    int c;
    for (int k = 0; k < 8; k++) begin
      for (int j = 1; j <= 4; j++) begin
        c = f + 1 + 4*k + j;
        a = lit[k] ? ~(8'd1 << k) : 8'hFF;
        s = lit[k] ? segs[7*k +: 7] : 7'h7F;
        if (c <= last_cyc) push_item(c, a, s, (c == f + 32), tag);
      end
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic write_value(input logic [31:0] v);
    value_in = v;
    value_we = 1'b1;
    @(negedge clk);
    value_we = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s expectation for cyc %0d was never compared", e.tag, e.cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check_output(e.tag, e.an, e.seg, e.fd);
    end
  end

  task automatic apply_stimulus();
    int c0, f0, f1, f2, f3, f4, b, f7, f8;
    rst = 1'b0;
    value_in = '0;
    value_we = 1'b0;
    blank = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_hold", 8'hFF, 7'h7F, 1'b0);

    rst = 1'b1;
    c0 = cyc;
    wait_until(c0 + 2);
    write_value(32'hDEAD_BEEF);

    // Mid-scan reset with a nonzero display; a write during reset must be dropped.
    wait_until(c0 + 45);
    rst = 1'b0;
    #1;
    check_output("reset_async", 8'hFF, 7'h7F, 1'b0);
    value_in = 32'h0000_CAFE;
    value_we = 1'b1;
    @(negedge clk);
    value_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_output("release", 8'hFF, 7'h7F, 1'b0);
    f0 = cyc - 1;

    push_frame(f0, ZERO_SEGS, LIT_ZERO, 1 << 30, "after_reset");
    push_frame(f0 + 32, ZERO_SEGS, LIT_ZERO, 1 << 30, "no_leak");
    wait_until(f0 + 40);
    write_value(32'h0000_00BB);
    f1 = f0 + 64;
    f2 = f1 + 32;
    push_frame(f1, BB_SEGS, LIT_BB, 1 << 30, "scan_bb");
    push_frame(f2, BB_SEGS, LIT_BB, 1 << 30, "no_tear");

    wait_until(f2 + 5);
    write_value(32'h0000_AAAA);
    wait_until(f2 + 13);
    write_value(32'h1234_5678);
    f3 = f2 + 32;
    push_frame(f3, NUM_SEGS, 8'hFF, 1 << 30, "new_frame");

    f4 = f3 + 32;
    b  = f4 + 28;
    push_frame(f4, F_SEGS, LIT_F, b, "boundary_wr");
    for (int c = b + 1; c <= b + 40; c++)
      push_item(c, 8'hFF, 7'h7F, (c == b + 4) || (c == b + 36), "blank");
    wait_until(f4);
    write_value(32'h0000_FFFF);
    vectors++;
    if (dut.pending !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL boundary_pending pending=%b want 0", dut.pending);
    end

    wait_until(b);
    blank = 1'b1;
    wait_until(b + 40);
    blank = 1'b0;

    f7 = b + 68;
    f8 = f7 + 32;
    push_frame(f7, F_SEGS, LIT_F, 1 << 30, "after_blank");
    push_frame(f8, ZERO_SEGS, LIT_ZERO, 1 << 30, "zero_value");
    wait_until(f7 + 5);
    write_value(32'h0000_0000);
    wait_until(f8 + 40);
  endtask

  initial begin
    apply_stimulus();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain left=%0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
